// File: rtl/sync_ringbuffer.sv
// Single-clock ring buffer; 2**BITS entries, all usable; drop-newest or overwrite-oldest when full.
// Latency: a pop registers read_data with read_valid one cycle after read_en; a push is readable the next cycle.
// Backpressure: no stall signals; a push to a full buffer drops or overwrites, and a pop of an empty buffer is ignored; both raise sticky flags.
module sync_ringbuffer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BITS        = 5,
   parameter int unsigned OVERWRITE   = 0,
   parameter int unsigned AFULL_LEVEL = (2**BITS) - 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic [BITS:0]         count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow,
   output logic [15:0]           drop_count,
   input  logic                  clear_flags
);

   localparam int unsigned   DEPTH   = 2**BITS;
   localparam logic [BITS:0] DEPTH_C = {1'b1, {BITS{1'b0}}};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [BITS-1:0]       wr_ptr;
   logic [BITS-1:0]       rd_ptr;
   logic [BITS:0]         count_q;
   logic [BITS:0]         count_nxt;

   logic rd_ok;    // pop accepted
   logic wr_ok;    // push stored into the array
   logic ovf_evt;  // push while full with no pop to make room
   logic udf_evt;  // pop while empty
   logic ovw;      // push overwrote the oldest entry
   logic rd_adv;   // read pointer moves this cycle

   assign count       = count_q;
   assign empty       = (count_q == '0);
   assign full        = (count_q == DEPTH_C);
   assign almost_full = (32'(count_q) >= AFULL_LEVEL);

   // Decode this cycle's accepted operations and the resulting occupancy.
   always_comb begin
      rd_ok     = read_en && !empty;
      udf_evt   = read_en && empty;
      // When full the buffer is non-empty, so read_en alone means a pop frees a slot.
      ovf_evt   = write_en && full && !read_en;
      ovw       = ovf_evt && (OVERWRITE != 0);
      wr_ok     = write_en && (!full || read_en || (OVERWRITE != 0));
      rd_adv    = rd_ok || ovw;
      count_nxt = count_q;
      if (wr_ok && !rd_ok && !ovw) begin
         count_nxt = count_q + (BITS+1)'(1);
      end else if (rd_ok && !wr_ok) begin
         count_nxt = count_q - (BITS+1)'(1);
      end
   end

   // Storage array; not reset, writes suppressed while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem[wr_ptr] <= write_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + BITS'(1);
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + BITS'(1);
         end
         count_q <= count_nxt;
      end
   end

   // Registered read port; read_data holds its value when nothing is popped.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= rd_ok;
         if (rd_ok) begin
            read_data <= mem[rd_ptr];
         end
      end
   end

   // Sticky error flags; a same-cycle event beats clear_flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         drop_count <= '0;
      end else begin
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end

         if (udf_evt) begin
            underflow <= 1'b1;
         end else if (clear_flags) begin
            underflow <= 1'b0;
         end

         if (ovf_evt) begin
            if (clear_flags) begin
               drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end else if (clear_flags) begin
            drop_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sync_ringbuffer.sv
// Bench for sync_ringbuffer: a drop-newest and an overwrite-oldest instance driven in lockstep.
// Expected pops are queued by the stimulus; per-instance monitors pop and compare on read_valid.
// Status outputs are compared directly one time unit after each clock edge.
module tb_sync_ringbuffer;

   localparam int DW = 8;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          write_en;
   logic [DW-1:0] write_data;
   logic          read_en;
   logic          clear_flags;

   logic [DW-1:0] rd0, rd1;
   logic          rv0, rv1;
   logic [BW:0]   cnt0, cnt1;
   logic          emp0, emp1, ful0, ful1, af0, af1;
   logic          ovf0, ovf1, udf0, udf1;
   logic [15:0]   drp0, drp1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   always #5 clk = ~clk;

   sync_ringbuffer #(.DATA_WIDTH(DW), .BITS(BW), .OVERWRITE(0), .AFULL_LEVEL(3)) dut0 (
      .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
      .read_en(read_en), .read_data(rd0), .read_valid(rv0), .count(cnt0),
      .empty(emp0), .full(ful0), .almost_full(af0), .overflow(ovf0),
      .underflow(udf0), .drop_count(drp0), .clear_flags(clear_flags)
   );

   sync_ringbuffer #(.DATA_WIDTH(DW), .BITS(BW), .OVERWRITE(1), .AFULL_LEVEL(3)) dut1 (
      .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
      .read_en(read_en), .read_data(rd1), .read_valid(rv1), .count(cnt1),
      .empty(emp1), .full(ful1), .almost_full(af1), .overflow(ovf1),
      .underflow(udf1), .drop_count(drp1), .clear_flags(clear_flags)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp);
      chk({name, "/drop"}, a0, exp);
      chk({name, "/ovwr"}, a1, exp);
   endtask

   // Apply one cycle of inputs, then step to just after the edge that samples them.
   task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic cf, input logic rs);
      write_en    = we;
      write_data  = wd;
      read_en     = re;
      clear_flags = cf;
      reset       = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      drive(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      q0.push_back(e0);
      q1.push_back(e1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor for the drop-newest instance.
   always @(negedge clk) begin
      if (rv0 === 1'b1) begin
         if (q0.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd0_unexpected: got %0h expected no read_valid", rd0);
         end else begin
            chk("rd0_data", 32'(rd0), 32'(q0.pop_front()));
         end
      end
   end

   // Scoreboard monitor for the overwrite-oldest instance.
   always @(negedge clk) begin
      if (rv1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd1_unexpected: got %0h expected no read_valid", rd1);
         end else begin
            chk("rd1_data", 32'(rd1), 32'(q1.pop_front()));
         end
      end
   end

   initial begin
      // Reset state.
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk2("rst_count", cnt0, cnt1, 0);
      chk2("rst_empty", emp0, emp1, 1);
      chk2("rst_full",  ful0, ful1, 0);
      chk2("rst_ovf",   ovf0, ovf1, 0);
      chk2("rst_udf",   udf0, udf1, 0);
      chk2("rst_drop",  drp0, drp1, 0);
      chk2("rst_rv",    rv0,  rv1,  0);
      chk2("rst_rdata", rd0,  rd1,  0);

      // Fill A..D and drain in order.
      push(8'hA1);
      push(8'hA2);
      chk2("af_at2", af0, af1, 0);
      push(8'hA3);
      chk2("af_at3", af0, af1, 1);
      chk2("cnt_at3", cnt0, cnt1, 3);
      push(8'hA4);
      chk2("fill_count", cnt0, cnt1, 4);
      chk2("fill_full",  ful0, ful1, 1);
      chk2("fill_empty", emp0, emp1, 0);
      pop(8'hA1, 8'hA1);
      chk2("pop_rv", rv0, rv1, 1);
      chk2("pop_full", ful0, ful1, 0);
      pop(8'hA2, 8'hA2);
      pop(8'hA3, 8'hA3);
      pop(8'hA4, 8'hA4);
      idle();
      chk2("drain_empty", emp0, emp1, 1);
      chk2("hold_rv",     rv0,  rv1,  0);
      chk2("hold_rdata",  rd0,  rd1,  8'hA4);

      // Write while full: drop newest vs overwrite oldest.
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      push(8'hA4);
      push(8'hE5);
      chk2("ovf_flag",  ovf0, ovf1, 1);
      chk2("ovf_drop",  drp0, drp1, 1);
      chk2("ovf_count", cnt0, cnt1, 4);
      pop(8'hA1, 8'hA2);
      pop(8'hA2, 8'hA3);
      pop(8'hA3, 8'hA4);
      pop(8'hA4, 8'hE5);
      idle();
      chk2("ovf_drain", emp0, emp1, 1);

      // Clear sticky flags.
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk2("clr_ovf",  ovf0, ovf1, 0);
      chk2("clr_drop", drp0, drp1, 0);

      // Pop and push together on an empty buffer.
      drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      chk2("udf_flag",  udf0, udf1, 1);
      chk2("udf_rv",    rv0,  rv1,  0);
      chk2("udf_count", cnt0, cnt1, 1);
      pop(8'h5A, 8'h5A);
      idle();
      chk2("udf_empty", emp0, emp1, 1);

      // Full with simultaneous pop+push for 10 cycles, pointers wrap.
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      push(8'hA4);
      for (int i = 0; i < 10; i++) begin
         logic [DW-1:0] exp_rd;
         if (i < 4) exp_rd = 8'hA1 + 8'(i);
         else       exp_rd = 8'hB0 + 8'(i - 4);
         q0.push_back(exp_rd);
         q1.push_back(exp_rd);
         drive(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0, 1'b0);
         chk2("rw_count", cnt0, cnt1, 4);
         chk2("rw_ovf",   ovf0, ovf1, 0);
      end
      pop(8'hB6, 8'hB6);
      pop(8'hB7, 8'hB7);
      pop(8'hB8, 8'hB8);
      pop(8'hB9, 8'hB9);
      idle();
      chk2("rw_empty", emp0, emp1, 1);

      // Overflow in the same cycle as clear_flags keeps the flag and restarts drop_count.
      push(8'hC1);
      push(8'hC2);
      push(8'hC3);
      push(8'hC4);
      push(8'hE5);
      push(8'hF6);
      chk2("drop_two", drp0, drp1, 2);
      drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      chk2("clrpri_ovf",  ovf0, ovf1, 1);
      chk2("clrpri_drop", drp0, drp1, 1);
      chk2("clrpri_udf",  udf0, udf1, 0);
      pop(8'hC1, 8'hC4);
      chk2("pre_rst_count", cnt0, cnt1, 3);

      // Reset mid-stream with write_en high.
      drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
      chk2("mrst_count", cnt0, cnt1, 0);
      chk2("mrst_empty", emp0, emp1, 1);
      chk2("mrst_ovf",   ovf0, ovf1, 0);
      chk2("mrst_udf",   udf0, udf1, 0);
      chk2("mrst_drop",  drp0, drp1, 0);
      chk2("mrst_rv",    rv0,  rv1,  0);
      chk2("mrst_rdata", rd0,  rd1,  0);
      idle();
      chk2("post_rst_count", cnt0, cnt1, 0);
      push(8'h99);
      pop(8'h99, 8'h99);
      idle();
      idle();
      chk2("final_empty", emp0, emp1, 1);
      chk("q0_drained", 32'(q0.size()), 0);
      chk("q1_drained", 32'(q1.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
